th_scan_sched: RTL

//  Array-level scheduler for the per-pixel threshold-scan controllers. It walks the enabled pixels in

---
 rtl/th_scan_pkg.sv | 19 +
 rtl/th_scan_pick.sv | 25 ++
 rtl/th_scan_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/th_scan_pkg.sv
// Shared types and constants for the pixel threshold-scan scheduler.
// Holds the scheduler state encoding and the captured result field widths.
package th_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_WAIT,
        S_REPORT,
        S_FINISH
    } state_t;

    localparam int BL_W = 10;
    localparam int NW_W = 4;

    localparam logic [7:0] ERRCNT_MAX = 8'hFF;

endpackage

// File: rtl/th_scan_pick.sv
// Combinational next-pixel finder: lowest set mask bit whose index is >= base.
module th_scan_pick #(
    parameter int NPIX = 16,
    parameter int IDW  = 4
) (
    input  logic [NPIX-1:0] mask,
    input  logic [IDW-1:0]  base,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Walk downward so the last qualifying hit is the lowest index.
        for (int i = NPIX - 1; i >= 0; i--) begin
            if (mask[i] && (IDW'(i) >= base)) begin
                found = 1'b1;
                idx   = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/th_scan_sched.sv
// Array-level threshold-scan scheduler: sequences enabled pixels one at a time,
// waits for scan-done or timeout, and presents each result on a valid/ready port.
module th_scan_sched
    import th_scan_pkg::*;
#(
    parameter int NPIX  = 16,
    parameter int IDW   = 4,
    parameter int TOW   = 16,
    parameter int BLANK = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Start,
    input  logic                   Abort,
    input  logic [NPIX-1:0]        PixMask,
    input  logic [TOW-1:0]         TimeoutCyc,
    output logic [NPIX-1:0]        PixCLKEn,
    output logic [NPIX-1:0]        PixScanStart,
    input  logic [NPIX-1:0]        PixScanDone,
    input  logic [NPIX*BL_W-1:0]   PixBL,
    input  logic [NPIX*NW_W-1:0]   PixNW,
    output logic                   ResValid,
    input  logic                   ResReady,
    output logic [IDW-1:0]         ResPix,
    output logic [BL_W-1:0]        ResBL,
    output logic [NW_W-1:0]        ResNW,
    output logic                   ResTimeout,
    output logic                   Busy,
    output logic                   Done,
    output logic [7:0]             ErrCnt
);

    localparam int BCW = (BLANK < 1) ? 1 : $clog2(BLANK + 1);
    localparam logic [IDW-1:0] LAST = IDW'(NPIX - 1);

    state_t          state;
    state_t          next_state;
    logic [NPIX-1:0] mask_q;
    logic [IDW-1:0]  base;
    logic [IDW-1:0]  cur;
    logic [TOW-1:0]  to_cnt;
    logic [BCW-1:0]  blank_cnt;
    logic [BL_W-1:0] res_bl;
    logic [NW_W-1:0] res_nw;
    logic            res_to;
    logic [7:0]      err_cnt;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic            blank_ok;
    logic            done_hit;
    logic            timeout_hit;
    logic [NPIX-1:0] cur_onehot;
    logic [BL_W-1:0] sel_bl;
    logic [NW_W-1:0] sel_nw;

    th_scan_pick #(
        .NPIX (NPIX),
        .IDW  (IDW)
    ) u_pick (
        .mask  (mask_q),
        .base  (base),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign cur_onehot  = {{(NPIX-1){1'b0}}, 1'b1} << cur;
    assign sel_bl      = PixBL[cur*BL_W +: BL_W];
    assign sel_nw      = PixNW[cur*NW_W +: NW_W];
    // A done level left over from an earlier scan is not trusted until BLANK WAIT cycles have passed.
    assign blank_ok    = (blank_cnt >= BCW'(BLANK));
    assign done_hit    = (state == S_WAIT) && blank_ok && PixScanDone[cur];
    assign timeout_hit = (state == S_WAIT) && (TimeoutCyc != '0) &&
                         (to_cnt == TimeoutCyc - TOW'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        PixCLKEn     = '0;
        PixScanStart = '0;
        ResValid     = 1'b0;
        Done         = 1'b0;
        Busy         = (state != S_IDLE);
        case (state)
            S_IDLE:   if (Start) next_state = S_SELECT;
            S_SELECT: next_state = pick_found ? S_ARM : S_FINISH;
            S_ARM: begin
                PixCLKEn   = cur_onehot;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                PixCLKEn     = cur_onehot;
                PixScanStart = cur_onehot;
                if (done_hit || timeout_hit) next_state = S_REPORT;
            end
            S_REPORT: begin
                ResValid = 1'b1;
                if (ResReady) next_state = (cur == LAST) ? S_FINISH : S_SELECT;
            end
            S_FINISH: begin
                Done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        if (Abort) next_state = S_IDLE;
    end

    // NOTE: the result and counter registers are all reset so the outputs read zero straight out of reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mask_q    <= '0;
            base      <= '0;
            cur       <= '0;
            to_cnt    <= '0;
            blank_cnt <= '0;
            res_bl    <= '0;
            res_nw    <= '0;
            res_to    <= 1'b0;
            err_cnt   <= '0;
        end else if (!Abort) begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        mask_q  <= PixMask;
                        err_cnt <= '0;
                        base    <= '0;
                    end
                end
                S_SELECT: begin
                    if (pick_found) cur <= pick_idx;
                end
                S_ARM: begin
                    to_cnt    <= '0;
                    blank_cnt <= '0;
                end
                S_WAIT: begin
                    to_cnt <= to_cnt + TOW'(1);
                    if (!blank_ok) blank_cnt <= blank_cnt + BCW'(1);
                    if (done_hit) begin
                        res_bl <= sel_bl;
                        res_nw <= sel_nw;
                        res_to <= 1'b0;
                    end else if (timeout_hit) begin
                        res_bl <= '0;
                        res_nw <= '0;
                        res_to <= 1'b1;
                        if (err_cnt != ERRCNT_MAX) err_cnt <= err_cnt + 8'd1;
                    end
                end
                S_REPORT: begin
                    if (ResReady) base <= (cur == LAST) ? '0 : cur + IDW'(1);
                end
                default: ;
            endcase
        end
    end

    assign ResPix     = cur;
    assign ResBL      = res_bl;
    assign ResNW      = res_nw;
    assign ResTimeout = res_to;
    assign ErrCnt     = err_cnt;

    a_onehot_pix : assert property (@(posedge CLK) disable iff (RST)
        $onehot0(PixCLKEn) && $onehot0(PixScanStart));

endmodule
